branch_hazard_ctrl: RTL and testbench

- Hazard controller for ID-stage branch resolution in the 5-stage RV32I pipeline.
- Detects RAW hazards between a branch/jalr in ID and older instructions in EX/MEM/WB, and sequences multi-cycle stalls with a small FSM and counter.
- Drives 2-bit forwarding selects for the two branch-comparator operands.
- Sits beside the decode stage: stall freezes PC and IF/ID and injects a bubble into ID/EX; forwarding selects steer the branch-comparator muxes.

---
 rtl/branch_hazard_ctrl_pkg.sv | 29 ++
 rtl/branch_hazard_ctrl_if.sv | 38 +++
 rtl/branch_hazard_ctrl_hazard_match.sv | 11 +
 rtl/branch_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared pipeline constants and types for the ID-stage branch hazard controller.
// The optional stall-cycle counter is built only when BRANCH_HAZARD_PERF_EN is defined.
`ifndef BRANCH_HAZARD_CONSTANTS_SV
`define BRANCH_HAZARD_CONSTANTS_SV
`define OPCODE_SIZE     7
`define REGFILE_LOGSIZE 5
`define BTYPE_OP        7'b1100011
`define JALR_OP         7'b1100111
`define FWD_RF          2'b00
`define FWD_MEM         2'b01
`define FWD_WB          2'b10
`endif

package branch_hazard_ctrl_pkg;
  localparam int OPCODE_W = `OPCODE_SIZE;
  localparam int REG_W    = `REGFILE_LOGSIZE;

  localparam logic [OPCODE_W-1:0] BTYPE_OP = `BTYPE_OP;
  localparam logic [OPCODE_W-1:0] JALR_OP  = `JALR_OP;

  localparam logic [1:0] FWD_RF  = `FWD_RF;
  localparam logic [1:0] FWD_MEM = `FWD_MEM;
  localparam logic [1:0] FWD_WB  = `FWD_WB;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } bhc_state_e;
endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Decode-side hazard bus: pipeline register destinations in, stall/forward selects out.
interface branch_hazard_ctrl_if;
  import branch_hazard_ctrl_pkg::*;

  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_W-1:0]    id_rs1;
  logic [REG_W-1:0]    id_rs2;
  logic [REG_W-1:0]    ex_rd;
  logic                ex_wr_en;
  logic                ex_is_load;
  logic [REG_W-1:0]    mem_rd;
  logic                mem_wr_en;
  logic                mem_is_load;
  logic [REG_W-1:0]    wb_rd;
  logic                wb_wr_en;
  logic                flush;
  logic                stall;
  logic [1:0]          br_fwsel1;
  logic [1:0]          br_fwsel2;
  logic [31:0]         perf_stall_cnt;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2,
    output ex_rd, ex_wr_en, ex_is_load,
    output mem_rd, mem_wr_en, mem_is_load,
    output wb_rd, wb_wr_en, flush,
    input  stall, br_fwsel1, br_fwsel2, perf_stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2,
    input  ex_rd, ex_wr_en, ex_is_load,
    input  mem_rd, mem_wr_en, mem_is_load,
    input  wb_rd, wb_wr_en, flush,
    output stall, br_fwsel1, br_fwsel2, perf_stall_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl_hazard_match.sv
// Source/destination register comparator; x0 never matches.
module hazard_match #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd,
  input  logic             en,
  output logic             hit
);
  assign hit = en && (rd != '0) && (rs == rd);
endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jalr hazard controller: stall sequencing and comparator forwarding.
// Define BRANCH_HAZARD_PERF_EN to build the 32-bit stall-cycle counter.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 2
) (
  input logic                 clk,
  input logic                 nrst,
  branch_hazard_ctrl_if.slave hz
);
  localparam int CNT_W = $clog2(MAX_STALL + 1);

  generate
    if (MAX_STALL < 2) begin : g_bad_max_stall
      $error("branch_hazard_ctrl: MAX_STALL must be at least 2");
    end
  endgenerate

  bhc_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] need;
  logic             stall;
  logic [1:0]       fwsel1, fwsel2;

  logic is_jalr, is_br;
  logic rs1_ex, rs1_mem, rs1_wb, rs2_ex, rs2_mem, rs2_wb;
  logic ex_hit_br, mem_hit_br, ex_hit_any;

  assign is_jalr = (hz.id_opcode == JALR_OP);
  assign is_br   = hz.id_valid && ((hz.id_opcode == BTYPE_OP) || is_jalr);

  hazard_match #(.REG_W(REG_W)) u_rs1_ex  (.rs(hz.id_rs1), .rd(hz.ex_rd),  .en(hz.ex_wr_en),  .hit(rs1_ex));
  hazard_match #(.REG_W(REG_W)) u_rs1_mem (.rs(hz.id_rs1), .rd(hz.mem_rd), .en(hz.mem_wr_en), .hit(rs1_mem));
  hazard_match #(.REG_W(REG_W)) u_rs1_wb  (.rs(hz.id_rs1), .rd(hz.wb_rd),  .en(hz.wb_wr_en),  .hit(rs1_wb));
  hazard_match #(.REG_W(REG_W)) u_rs2_ex  (.rs(hz.id_rs2), .rd(hz.ex_rd),  .en(hz.ex_wr_en),  .hit(rs2_ex));
  hazard_match #(.REG_W(REG_W)) u_rs2_mem (.rs(hz.id_rs2), .rd(hz.mem_rd), .en(hz.mem_wr_en), .hit(rs2_mem));
  hazard_match #(.REG_W(REG_W)) u_rs2_wb  (.rs(hz.id_rs2), .rd(hz.wb_rd),  .en(hz.wb_wr_en),  .hit(rs2_wb));

  // jalr has no rs2 operand, so its rs2 field must not create a branch hazard
  assign ex_hit_br  = rs1_ex  || (rs2_ex  && !is_jalr);
  assign mem_hit_br = rs1_mem || (rs2_mem && !is_jalr);
  assign ex_hit_any = rs1_ex  || rs2_ex;

  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit,
                                         input logic mem_ld);
    if (mem_hit && !mem_ld) return FWD_MEM;
    if (wb_hit)             return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    need = '0;
    if (is_br && ex_hit_br && hz.ex_is_load)           need = CNT_W'(2);
    else if (is_br && ex_hit_br)                       need = CNT_W'(1);
    else if (is_br && mem_hit_br && hz.mem_is_load)    need = CNT_W'(1);
    else if (hz.id_valid && !is_br && ex_hit_any && hz.ex_is_load) need = CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    if (hz.flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (need != '0) stall = 1'b1;
          if (need > CNT_W'(1)) begin
            state_d = STALL;
            rem_d   = need - CNT_W'(1);
          end
        end
        STALL: begin
          stall = 1'b1;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q <= CNT_W'(1)) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    fwsel1 = FWD_RF;
    fwsel2 = FWD_RF;
    if (is_br && !stall) begin
      fwsel1 = fwd_sel(rs1_mem, rs1_wb, hz.mem_is_load);
      if (!is_jalr) fwsel2 = fwd_sel(rs2_mem, rs2_wb, hz.mem_is_load);
    end
  end

  assign hz.stall     = stall;
  assign hz.br_fwsel1 = fwsel1;
  assign hz.br_fwsel2 = fwsel2;

`ifdef BRANCH_HAZARD_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (!nrst)      perf_q <= '0;
    else if (stall) perf_q <= perf_q + 32'd1;
  end

  assign hz.perf_stall_cnt = perf_q;
`else
  assign hz.perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed pipeline scenarios then random traffic.
module tb_branch_hazard_ctrl;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  branch_hazard_ctrl_if bus ();

  branch_hazard_ctrl #(.MAX_STALL(2)) dut (
    .clk  (clk),
    .nrst (nrst),
    .hz   (bus)
  );

  int          vectors   = 0;
  int          miscompares = 0;
  int          pend      = 0;   // forced stall cycles still owed after the current one
  logic [31:0] perf_exp  = '0;

  function automatic bit m(input logic [4:0] rs, input logic [4:0] rd, input logic en);
    return en && (rd != 5'd0) && (rs == rd);
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] rs);
    if (m(rs, bus.mem_rd, bus.mem_wr_en) && !bus.mem_is_load) return 2'b01;
    if (m(rs, bus.wb_rd, bus.wb_wr_en)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
    bus.id_valid = v; bus.id_opcode = op; bus.id_rs1 = r1; bus.id_rs2 = r2;
  endtask
  task automatic set_ex(input logic [4:0] rd, input logic wr, input logic ld);
    bus.ex_rd = rd; bus.ex_wr_en = wr; bus.ex_is_load = ld;
  endtask
  task automatic set_mem(input logic [4:0] rd, input logic wr, input logic ld);
    bus.mem_rd = rd; bus.mem_wr_en = wr; bus.mem_is_load = ld;
  endtask
  task automatic set_wb(input logic [4:0] rd, input logic wr);
    bus.wb_rd = rd; bus.wb_wr_en = wr;
  endtask
  task automatic ctl(input logic fl, input logic rn);
    bus.flush = fl; nrst = rn;
  endtask

  task automatic chk2(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs against the model, then advance both.
  task automatic step(input string tag);
    int         need;
    bit         br, jr, exh, memh;
    logic       exp_stall;
    logic [1:0] e1, e2;
    need = 0;
    #1;
    jr   = (bus.id_opcode == OP_JALR);
    br   = bus.id_valid && (bus.id_opcode == OP_BR || jr);
    exh  = m(bus.id_rs1, bus.ex_rd, bus.ex_wr_en) || (!jr && m(bus.id_rs2, bus.ex_rd, bus.ex_wr_en));
    memh = m(bus.id_rs1, bus.mem_rd, bus.mem_wr_en) || (!jr && m(bus.id_rs2, bus.mem_rd, bus.mem_wr_en));
    if (bus.flush) exp_stall = 1'b0;
    else if (pend > 0) exp_stall = 1'b1;
    else begin
      if (br && exh && bus.ex_is_load) need = 2;
      else if (br && exh) need = 1;
      else if (br && memh && bus.mem_is_load) need = 1;
      else if (bus.id_valid && !br && bus.ex_is_load &&
               (m(bus.id_rs1, bus.ex_rd, bus.ex_wr_en) || m(bus.id_rs2, bus.ex_rd, bus.ex_wr_en)))
        need = 1;
      exp_stall = (need > 0);
    end
    e1 = 2'b00; e2 = 2'b00;
    if (br && !exp_stall) begin
      e1 = fsel(bus.id_rs1);
      if (!jr) e2 = fsel(bus.id_rs2);
    end
    chk2({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
    chk2({tag, ".fwsel1"}, 32'(bus.br_fwsel1), 32'(e1));
    chk2({tag, ".fwsel2"}, 32'(bus.br_fwsel2), 32'(e2));
`ifdef BRANCH_HAZARD_PERF_EN
    chk2({tag, ".perf"}, bus.perf_stall_cnt, perf_exp);
`else
    chk2({tag, ".perf"}, bus.perf_stall_cnt, 32'd0);
`endif
    @(posedge clk);
    if (!nrst) begin
      pend = 0; perf_exp = '0;
    end else begin
      if (exp_stall) perf_exp = perf_exp + 32'd1;
      if (bus.flush) pend = 0;
      else if (pend > 0) pend--;
      else if (need > 0) pend = need - 1;
    end
    #1;
  endtask

  task automatic idle_pipe();
    set_id(1'b0, OP_ALU, 5'd0, 5'd0);
    set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd0, 1'b0, 1'b0); set_wb(5'd0, 1'b0);
  endtask

  initial begin
    idle_pipe();
    ctl(1'b0, 1'b0);
    @(posedge clk); #1;
    step("reset");
    ctl(1'b0, 1'b1);
    step("idle");

    // ALU result in EX feeding beq: one stall, then forward from MEM
    set_id(1'b1, OP_BR, 5'd1, 5'd5); set_ex(5'd1, 1'b1, 1'b0);
    step("beq_ex_alu");
    set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd1, 1'b1, 1'b0);
    step("beq_mem_fwd");

    // Load in EX feeding bne: two stalls, then both operands from WB
    idle_pipe(); set_id(1'b1, OP_BR, 5'd3, 5'd3); set_ex(5'd3, 1'b1, 1'b1);
    step("bne_ld_s1");
    set_ex(5'd0, 1'b0, 1'b0); set_mem(5'd3, 1'b1, 1'b1);
    step("bne_ld_s2");
    set_mem(5'd0, 1'b0, 1'b0); set_wb(5'd3, 1'b1);
    step("bne_wb_fwd");

    // MEM beats WB; x0 never forwards
    idle_pipe(); set_id(1'b1, OP_BR, 5'd7, 5'd7); set_mem(5'd7, 1'b1, 1'b0); set_wb(5'd7, 1'b1);
    step("mem_prio");
    set_id(1'b1, OP_BR, 5'd0, 5'd0); set_mem(5'd0, 1'b1, 1'b0); set_wb(5'd0, 1'b1); set_ex(5'd0, 1'b1, 1'b1);
    step("x0");

    // Load-use on a plain ALU op, and jalr behind an ALU op
    idle_pipe(); set_id(1'b1, OP_ALU, 5'd4, 5'd2); set_ex(5'd4, 1'b1, 1'b1);
    step("load_use");
    set_ex(5'd0, 1'b0, 1'b0);
    step("load_use_done");
    set_id(1'b1, OP_JALR, 5'd4, 5'd9); set_ex(5'd4, 1'b1, 1'b0);
    step("jalr_ex");
    set_id(1'b1, OP_JALR, 5'd8, 5'd4);
    step("jalr_rs2_ignored");

    // Flush in the middle of a two-cycle stall
    idle_pipe(); set_id(1'b1, OP_BR, 5'd3, 5'd6); set_ex(5'd3, 1'b1, 1'b1);
    step("flush_s1");
    ctl(1'b1, 1'b1);
    step("flush_hit");
    ctl(1'b0, 1'b1); idle_pipe();
    step("flush_after");

    // Reset in the middle of a two-cycle stall
    set_id(1'b1, OP_BR, 5'd2, 5'd2); set_ex(5'd2, 1'b1, 1'b1);
    step("rst_s1");
    ctl(1'b0, 1'b0); idle_pipe();
    step("rst_hit");
    ctl(1'b0, 1'b1);
    step("rst_after");

    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 3))
        0, 1:    op = OP_BR;
        2:       op = OP_JALR;
        default: op = OP_ALU;
      endcase
      set_id(($urandom_range(0, 7) != 0), op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      set_ex(5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      set_mem(5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      set_wb(5'($urandom_range(0, 3)), 1'($urandom));
      ctl(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) != 0));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
